// File: rtl/dec_bcd_pkg.sv
// Shared widths and constants for the keypad decimal-to-BCD encoder path.
package dec_bcd_pkg;

   localparam int DEC_W = 10;
   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] BCD_INVALID = 4'd0;

endpackage

// File: rtl/dec_priority_enc.sv
// Combinational priority encoder: index of the highest set key line.
module dec_priority_enc
   import dec_bcd_pkg::*;
(
   input  logic [DEC_W-1:0] dec,
   output logic [BCD_W-1:0] idx,
   output logic             any_set
);

   // Highest key wins when several lines are pressed together.
   always_comb begin
      idx     = BCD_INVALID;
      any_set = |dec;
      if      (dec[9]) idx = 4'd9;
      else if (dec[8]) idx = 4'd8;
      else if (dec[7]) idx = 4'd7;
      else if (dec[6]) idx = 4'd6;
      else if (dec[5]) idx = 4'd5;
      else if (dec[4]) idx = 4'd4;
      else if (dec[3]) idx = 4'd3;
      else if (dec[2]) idx = 4'd2;
      else if (dec[1]) idx = 4'd1;
      else if (dec[0]) idx = 4'd0;
   end

endmodule

// File: rtl/dec_to_bcd_encoder.sv
// Registered keypad encoder: 10 key lines to a BCD digit plus a level valid flag,
// gated by EN, one cycle of latency.
module dec_to_bcd_encoder
   import dec_bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [DEC_W-1:0] DEC,
   input  logic             EN,
   output logic [BCD_W-1:0] BCD,
   output logic             DATA_VALID
);

   logic [BCD_W-1:0] idx;
   logic             any_set;
   logic             valid_n;
   logic [BCD_W-1:0] bcd_n;

   dec_priority_enc u_prio (
      .dec     (DEC),
      .idx     (idx),
      .any_set (any_set)
   );

   // Forcing BCD to BCD_INVALID when not valid keeps idle output at a known 0.
   assign valid_n = EN & any_set;
   assign bcd_n   = valid_n ? idx : BCD_INVALID;

   always_ff @(posedge clk) begin
      if (reset) begin
         BCD        <= BCD_INVALID;
         DATA_VALID <= 1'b0;
      end else begin
         BCD        <= bcd_n;
         DATA_VALID <= valid_n;
      end
   end

endmodule

// File: tb/tb_dec_to_bcd_encoder.sv
// Scoreboard bench for dec_to_bcd_encoder: directed plan followed by random keys.
module tb_dec_to_bcd_encoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       EN = 1'b0;
   logic [9:0] DEC = 10'd0;
   logic [3:0] BCD;
   logic       DATA_VALID;

   always #5 clk = ~clk;

   dec_to_bcd_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .DEC        (DEC),
      .EN         (EN),
      .BCD        (BCD),
      .DATA_VALID (DATA_VALID)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [9:0] dec;
      logic [3:0] bcd;
      logic       vld;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference: the digit is floor(log2(DEC)) for a nonzero key vector.
   function automatic exp_t model(input logic r, input logic e, input logic [9:0] d);
      exp_t x;
      int   v;
      int   h;
      x.rst = r; x.en = e; x.dec = d;
      x.bcd = 4'd0; x.vld = 1'b0;
      if (!r && e && d != 10'd0) begin
         v = int'(d);
         h = 0;
         while (v > 1) begin
            v = v / 2;
            h = h + 1;
         end
         x.bcd = 4'(h);
         x.vld = 1'b1;
      end
      return x;
   endfunction

   task automatic apply(input logic r, input logic e, input logic [9:0] d);
      @(negedge clk);
      reset = r;
      EN    = e;
      DEC   = d;
      sb.push_back(model(r, e, d));
   endtask

   // Monitor: every edge registers one applied input, so pop one entry per edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            if (BCD === x.bcd && DATA_VALID === x.vld)
               n_pass++;
            else
               $display("FAIL enc rst=%0b en=%0b dec=%b: got bcd=%0d vld=%b, want bcd=%0d vld=%b",
                        x.rst, x.en, x.dec, BCD, DATA_VALID, x.bcd, x.vld);
         end
      end
   end

   initial begin
      logic [9:0] d;
      logic       e;
      logic       r;
      int         mode;

      // Reset dominates a pressed key, then the first free edge shows it.
      apply(1'b1, 1'b1, 10'b0000001000);
      apply(1'b1, 1'b1, 10'b0000001000);
      apply(1'b0, 1'b1, 10'b0000001000);

      for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 10'(1 << i));
      for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, 10'(1 << i));
      apply(1'b0, 1'b1, 10'd0);

      apply(1'b0, 1'b1, 10'b0000100001);
      apply(1'b0, 1'b1, 10'b1000000100);
      apply(1'b0, 1'b1, 10'b0000101000);
      apply(1'b0, 1'b1, 10'b1000000001);

      apply(1'b0, 1'b1, 10'b0010000000);
      apply(1'b0, 1'b0, 10'b0010000000);

      for (int i = 0; i < 300; i++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0:       d = 10'd0;
            1:       d = 10'(1 << $urandom_range(0, 9));
            default: d = 10'($urandom_range(0, 1023));
         endcase
         e = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 19) == 0);
         apply(r, e, d);
      end

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected outputs never observed, want 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
